// File: rtl/sysbus_rr_arbiter.sv
// sysbus_rr_arbiter: round-robin sharing of the Sysbus memory port between instruction fetch (ch0) and data access (ch1)
module sysbus_rr_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      reqcyc0,
    output logic                      reqack0,
    input  logic [BUS_DATA_WIDTH-1:0] req0,
    input  logic [BUS_TAG_WIDTH-1:0]  reqtag0,
    output logic                      respcyc0,
    input  logic                      respack0,
    output logic [BUS_DATA_WIDTH-1:0] resp0,
    output logic [BUS_TAG_WIDTH-1:0]  resptag0,
    input  logic                      reqcyc1,
    output logic                      reqack1,
    input  logic [BUS_DATA_WIDTH-1:0] req1,
    input  logic [BUS_TAG_WIDTH-1:0]  reqtag1,
    output logic                      respcyc1,
    input  logic                      respack1,
    output logic [BUS_DATA_WIDTH-1:0] resp1,
    output logic [BUS_TAG_WIDTH-1:0]  resptag1,
    output logic                      bus_reqcyc,
    input  logic                      bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      grant_valid,
    output logic                      grant_id
);
    localparam int CW = $clog2(BEATS) + 1;
    localparam logic SYSBUS_WRITE = 1'b1;
    typedef enum logic [1:0] {IDLE, HDR, WDATA, RDATA} state_t;
    state_t state;
    logic owner, prio;
    logic [CW-1:0] beat_cnt;
    logic sending, reading, own_reqcyc, own_respack, req_hs, resp_hs, last;
    logic [BUS_DATA_WIDTH-1:0] own_req;
    logic [BUS_TAG_WIDTH-1:0] own_reqtag;

    // select the owner's request/response-side inputs and detect handshakes
    always_comb begin
        sending = state == HDR || state == WDATA;
        reading = state == RDATA;
        own_reqcyc = owner ? reqcyc1 : reqcyc0;
        own_req = owner ? req1 : req0;
        own_reqtag = owner ? reqtag1 : reqtag0;
        own_respack = owner ? respack1 : respack0;
        req_hs = sending && own_reqcyc && bus_reqack;
        resp_hs = reading && bus_respcyc && own_respack;
        last = beat_cnt == CW'(BEATS - 1);
    end

    // transaction sequencing, ownership and round-robin priority update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            prio <= 1'b0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (reqcyc0 || reqcyc1) begin
                    owner <= (reqcyc0 && reqcyc1) ? prio : reqcyc1;
                    state <= HDR;
                end
                HDR: if (req_hs) begin
                    state <= (own_reqtag[BUS_TAG_WIDTH-1] == SYSBUS_WRITE) ? WDATA : RDATA;
                    beat_cnt <= '0;
                end
                WDATA, RDATA: if ((state == WDATA) ? req_hs : resp_hs) begin
                    beat_cnt <= beat_cnt + CW'(1);
                    if (last) begin
                        state <= IDLE;
                        prio <= ~owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // forward owner handshakes to memory and back; the non-owner sees only zeros
    always_comb begin
        reqack0 = sending && !owner && bus_reqack;
        reqack1 = sending && owner && bus_reqack;
        bus_reqcyc = sending && own_reqcyc;
        bus_req = sending ? own_req : '0;
        bus_reqtag = sending ? own_reqtag : '0;
        respcyc0 = reading && !owner && bus_respcyc;
        respcyc1 = reading && owner && bus_respcyc;
        resp0 = (reading && !owner) ? bus_resp : '0;
        resp1 = (reading && owner) ? bus_resp : '0;
        resptag0 = (reading && !owner) ? bus_resptag : '0;
        resptag1 = (reading && owner) ? bus_resptag : '0;
        bus_respack = reading && own_respack;
        grant_valid = state != IDLE;
        grant_id = grant_valid && owner;
    end
endmodule
